hex2physical: RTL and testbench

HEX2PHYSICAL -- requirements
Module: hex2physical

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/hex2seg_lut.sv | 13 +
 rtl/hex2physical.sv | 35 +++
 tb/tb_hex2physical.sv | 125 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low blank pattern and digit table.
package seg7_pkg;

  typedef struct packed {
    logic       en;
    logic [3:0] digit;
  } hex_in_t;

  typedef logic [15:0][7:0] seg_table_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry i is the cathode pattern for digit i; dp (bit7) is always dark.
  // b and d are lowercase so they cannot be confused with 8 and 0.
  localparam seg_table_t SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex2seg_lut.sv
// Combinational hex digit to active-low seven-segment cathode pattern.
module hex2seg_lut
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/hex2physical.sv
// Registered seven-segment driver: enable mux, reset mux, one output flop.
module hex2physical
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hex,
  output logic [7:0] cathodes
);

  hex_in_t    hex_s;
  logic [7:0] seg_lut;
  logic [7:0] cathodes_d;
  logic [7:0] cathodes_q;

  assign hex_s = hex_in_t'(hex);

  hex2seg_lut u_lut (
    .digit (hex_s.digit),
    .seg   (seg_lut)
  );

  always_comb begin
    cathodes_d = hex_s.en ? seg_lut : SEG_BLANK;
  end

  // Reset wins over the decoded value so the display goes dark on the next edge.
  always_ff @(posedge clk) begin
    if (rst) cathodes_q <= SEG_BLANK;
    else     cathodes_q <= cathodes_d;
  end

  assign cathodes = cathodes_q;

endmodule

// File: tb/tb_hex2physical.sv
// Scoreboard bench for hex2physical: driver queues expected cathodes, monitor compares.
module tb_hex2physical;

  logic       clk;
  logic       rst;
  logic [4:0] hex;
  logic [7:0] cathodes;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         pass_cnt;
  int         total_cnt;

  // Hand-written digit table, indexed by digit value.
  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  hex2physical dut (
    .clk      (clk),
    .rst      (rst),
    .hex      (hex),
    .cathodes (cathodes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_cath(input logic r, input logic [4:0] h);
    if (r)          return 8'hFF;
    else if (!h[4]) return 8'hFF;
    else            return tbl[h[3:0]];
  endfunction

  // Inputs change on the falling edge; the expectation is queued once the rising edge has sampled them.
  task automatic drive(input logic r, input logic [4:0] h, input logic [7:0] exp_v, input string nm);
    @(negedge clk);
    rst = r;
    hex = h;
    @(posedge clk);
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
  endtask

  // Monitor: the registered output is stable at each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total_cnt++;
      if ($isunknown(cathodes) || cathodes !== e)
        $display("FAIL %s: cathodes=%h expected=%h hex=%h rst=%b t=%0t", nm, cathodes, e, hex, rst, $time);
      else
        pass_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [4:0] h;
    logic       r;
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    hex = 5'h1F;

    // Reset held for two cycles with a lit digit on the input.
    drive(1'b1, 5'h1F, 8'hFF, "reset0");
    drive(1'b1, 5'h1F, 8'hFF, "reset1");
    // First edge out of reset reflects hex sampled at that edge.
    drive(1'b0, 5'h1F, 8'h8E, "first_after_reset");

    // Disabled: every digit is dark.
    for (int i = 0; i < 16; i++)
      drive(1'b0, {1'b0, 4'(i)}, 8'hFF, "disabled_sweep");

    // Enabled sweep, one digit per cycle.
    for (int i = 0; i < 16; i++)
      drive(1'b0, {1'b1, 4'(i)}, tbl[i], "enabled_sweep");

    // Spot checks with literal expectations.
    drive(1'b0, 5'h10, 8'hC0, "digit_0");
    drive(1'b0, 5'h1B, 8'h83, "digit_b");
    drive(1'b0, 5'h1D, 8'hA1, "digit_d");
    drive(1'b0, 5'h1F, 8'h8E, "digit_F");

    // Enable toggling every cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'h18, 8'h80, "toggle_on");
      drive(1'b0, 5'h08, 8'hFF, "toggle_off");
    end

    // Single-cycle reset pulse mid-operation.
    drive(1'b0, 5'h12, 8'hA4, "steady_a4");
    drive(1'b0, 5'h12, 8'hA4, "steady_a4");
    drive(1'b1, 5'h12, 8'hFF, "mid_reset");
    drive(1'b0, 5'h12, 8'hA4, "after_mid_reset");

    // Random traffic, with occasional reset pulses.
    for (int i = 0; i < 1000; i++) begin
      h = 5'($urandom_range(0, 31));
      r = ($urandom_range(0, 31) == 0);
      drive(r, h, ref_cath(r, h), "random");
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
